// File: rtl/mips_pkg.sv
// mips_pkg
// Shared encodings for the multicycle MIPS controller: FSM states, opcode
// and funct constants, alu_control words and the 2-bit ALU operation class
// passed from the main FSM to the ALU decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
    JEX
  } state_t;

  // ALU operation class requested by the main FSM
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Combinational translation of the FSM's ALU operation class plus the
// instruction funct field into the 3-bit alu_control word.
// Ports:
//   alu_op      in  2  operation class from the main FSM
//   funct       in  6  instruction[5:0]
//   alu_control out 3  ALU function select
import mips_pkg::*;

module alu_decoder (
  input  alu_op_t     alu_op,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALUC_ADD;
      ALUOP_SUB: alu_control = ALUC_SUB;
      ALUOP_FUNCT: begin
        // Unrecognised funct codes execute as add and still write back.
        case (funct)
          FUNCT_ADD: alu_control = ALUC_ADD;
          FUNCT_SUB: alu_control = ALUC_SUB;
          FUNCT_AND: alu_control = ALUC_AND;
          FUNCT_OR:  alu_control = ALUC_OR;
          FUNCT_SLT: alu_control = ALUC_SLT;
          default:   alu_control = ALUC_ADD;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// mips_control_unit
// Moore main FSM of a multicycle MIPS core (lw, sw, R-type, beq, addi, j)
// plus the ALU decoder. Produces every mux select and write enable of the
// datapath.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   op, funct             instruction[31:26], instruction[5:0]
//   zero                  ALU result == 0 (used only to resolve beq)
//   alu_control           ALU function select
//   alu_src_a, alu_src_b  ALU operand selects
//   pc_src, pc_en         next-PC select and PC load enable
//   iord                  memory address select (PC / ALUOut)
//   ir_write, mem_write, reg_write   write enables
//   reg_dst, mem_to_reg   register-file write address / data selects
import mips_pkg::*;

module mips_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_en
);

  state_t  state_reg, state_next;
  state_t  cur_state;
  alu_op_t alu_op;
  logic    pc_write, branch;
  logic    ir_write_raw, mem_write_raw, reg_write_raw;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  // While reset is held the selects present FETCH values regardless of the
  // (possibly stale) state register; enables are masked further below.
  assign cur_state = reset ? FETCH : state_reg;

  always_comb begin
    state_next    = FETCH;
    alu_op        = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    iord          = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    case (cur_state)
      FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
        state_next   = DECODE;
      end
      DECODE: begin
        // Branch target precomputed into ALUOut
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
      end
      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  assign ir_write  = ir_write_raw  & ~reset;
  assign mem_write = mem_write_raw & ~reset;
  assign reg_write = reg_write_raw & ~reset;
  assign pc_en     = (pc_write | (branch & zero)) & ~reset;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_mips_control_unit.sv
// Testbench for mips_control_unit: directed instruction sequences, a
// per-instruction-cycle reference model, and a single compare process that
// checks the full output vector on every cycle.
module tb_mips_control_unit;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_en;
  } outs_t;

  typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_BAD} kind_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = 6'b000000;
  logic       zero = 1'b0;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en;

  int    n_cmp = 0;
  int    n_fail = 0;
  logic  check_en = 1'b0;
  outs_t exp_vec;
  outs_t act_vec;
  string cur_tag = "reset";
  int    cur_step = 0;

  mips_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .iord        (iord),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .pc_en       (pc_en)
  );

  always #5 clk = ~clk;

  assign act_vec = '{alu_control, alu_src_a, alu_src_b, pc_src, iord, ir_write,
                     mem_write, reg_write, reg_dst, mem_to_reg, pc_en};

  // ---------------- reference model ----------------
  function automatic int instr_len(kind_t k);
    case (k)
      K_LW:    return 5;
      K_SW:    return 4;
      K_R:     return 4;
      K_ADDI:  return 4;
      K_BEQ:   return 3;
      K_J:     return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [5:0] op_of(kind_t k);
    case (k)
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_R:     return 6'b000000;
      K_BEQ:   return 6'b000100;
      K_ADDI:  return 6'b001000;
      K_J:     return 6'b000010;
      default: return 6'b111111;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic outs_t reset_vec();
    outs_t o = '0;
    o.alu_control = 3'b010;
    o.alu_src_b   = 2'b01;
    return o;
  endfunction

  // Expected outputs for cycle 'step' (0 = fetch) of an instruction of kind k.
  function automatic outs_t model(kind_t k, int step, logic [5:0] f, logic z);
    outs_t o = '0;
    o.alu_control = 3'b010;
    if (step == 0) begin
      o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_en = 1'b1;
    end else if (step == 1) begin
      o.alu_src_b = 2'b11;
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (step == 2) begin
            o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
          end else if (k == K_SW) begin
            o.iord = 1'b1; o.mem_write = 1'b1;
          end else if (step == 3) begin
            o.iord = 1'b1;
          end else begin
            o.mem_to_reg = 1'b1; o.reg_write = 1'b1;
          end
        end
        K_R: begin
          if (step == 2) begin
            o.alu_src_a = 1'b1; o.alu_control = r_alu(f);
          end else begin
            o.reg_dst = 1'b1; o.reg_write = 1'b1;
          end
        end
        K_BEQ: begin
          o.alu_src_a = 1'b1; o.alu_control = 3'b110;
          o.pc_src = 2'b01; o.pc_en = z;
        end
        K_ADDI: begin
          if (step == 2) begin
            o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
          end else begin
            o.reg_write = 1'b1;
          end
        end
        K_J: begin
          o.pc_src = 2'b10; o.pc_en = 1'b1;
        end
        default: ;
      endcase
    end
    return o;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL %s step %0d: got %b required %b", cur_tag, cur_step, act_vec, exp_vec);
      end
    end
  end

  task automatic lit_check(string name, logic [2:0] act, logic [2:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Run one instruction; abort_step >= 0 asserts reset in that cycle.
  task automatic run_instr(kind_t k, logic [5:0] f, logic z, int abort_step);
    int len = instr_len(k);
    for (int s = 0; s < len; s++) begin
      @(posedge clk);
      #1;
      op       = op_of(k);
      funct    = f;
      cur_step = s;
      cur_tag  = k.name();
      // zero is only meaningful in the beq execute cycle; elsewhere it is noise
      zero     = (k == K_BEQ && s == 2) ? z : 1'($urandom_range(0, 1));
      if (s == abort_step) begin
        reset   = 1'b1;
        exp_vec = reset_vec();
      end else begin
        reset   = 1'b0;
        exp_vec = model(k, s, f, zero);
      end
      check_en = 1'b1;
      @(negedge clk);
      #1;
      if (k == K_BEQ && s == 2) begin
        lit_check("beq_pc_src", {1'b0, pc_src}, 3'b001);
        lit_check("beq_alu_control", alu_control, 3'b110);
        lit_check("beq_pc_en", {2'b00, pc_en}, {2'b00, z});
      end
      if (k == K_LW && s == 4)
        lit_check("lw_memwb_mem_to_reg_reg_write", {1'b0, mem_to_reg, reg_write}, 3'b011);
      if (k == K_J && s == 2)
        lit_check("j_pc_src_pc_en", {pc_src, pc_en}, 3'b101);
      if (s == abort_step) begin
        $display("txn %s op=%b funct=%b aborted by reset at step %0d", k.name(), op_of(k), f, s);
        return;
      end
    end
    $display("txn %s op=%b funct=%b zero=%b cycles=%0d", k.name(), op_of(k), f, z, len);
  endtask

  initial begin
    // Reset held three cycles with a lw opcode present
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      exp_vec  = reset_vec();
      cur_tag  = "reset";
      cur_step = i;
      check_en = 1'b1;
      @(negedge clk);
      #1;
      if (i == 2) lit_check("reset_alu_control", alu_control, 3'b010);
    end
    $display("txn RESET held 3 cycles");

    run_instr(K_LW,   6'b000000, 1'b0, -1);
    run_instr(K_R,    6'b100010, 1'b0, -1);
    run_instr(K_R,    6'b100100, 1'b0, -1);
    run_instr(K_R,    6'b100101, 1'b0, -1);
    run_instr(K_R,    6'b101010, 1'b0, -1);
    run_instr(K_R,    6'b000000, 1'b0, -1);
    run_instr(K_BEQ,  6'b000000, 1'b1, -1);
    run_instr(K_BEQ,  6'b000000, 1'b0, -1);
    run_instr(K_SW,   6'b000000, 1'b0, -1);
    run_instr(K_J,    6'b000000, 1'b0, -1);
    run_instr(K_ADDI, 6'b000000, 1'b0, -1);
    run_instr(K_BAD,  6'b101010, 1'b0, -1);
    run_instr(K_LW,   6'b000000, 1'b0, 3);
    run_instr(K_R,    6'b100000, 1'b0, -1);
    run_instr(K_SW,   6'b000000, 1'b0, 2);
    run_instr(K_LW,   6'b000000, 1'b0, -1);
    run_instr(K_BEQ,  6'b000000, 1'b1, -1);

    @(posedge clk);
    check_en = 1'b0;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
